// File: rtl/candy_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
//   wb_state_e  : writeback FSM state (idle / SRAM write in progress)
//   WbCntWidth  : width of the SRAM write-cycle counter (SRAM_WR_CYCLES up to 15)
package candy_wb_arbiter_pkg;

    typedef enum logic {
        WbIdle     = 1'b0,
        WbSramBusy = 1'b1
    } wb_state_e;

    localparam int unsigned WbCntWidth = 4;

endpackage

// File: rtl/candy_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk      : clock
//   rst      : asynchronous active-low reset (pointer resets to 1 so index 0 wins first)
//   eligible : per-index request qualifier
//   grant    : one-hot (or zero) grant, combinational from eligible and pointer
module candy_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        // Both eligible: the index that did not win last is favoured.
        if (eligible == 2'b11) begin
            grant = ptr_q ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
        // A grant is only ever given to a valid requester, and ready == grant,
        // so any grant is a completed handshake.
        if (grant[0]) begin
            ptr_d = 1'b0;
        end else if (grant[1]) begin
            ptr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/candy_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port and the SRAM write port between
// req0 (ALU/exec) and req1 (load/mem unit) with round-robin arbitration.
//   clk, rst                      : clock, asynchronous active-low reset
//   reqN_valid/ready              : per-requester handshake (ready is combinational)
//   reqN_is_mem                   : 1 = SRAM write, 0 = register write
//   reqN_data/sram_addr/reg_addr  : request payload, sampled on handshake only
//   reg_write_enable/waddr/wdata  : one-cycle register write strobe with registered payload
//   sram_write_enable/waddr/wdata : SRAM write held for SRAM_WR_CYCLES cycles
//   busy                          : SRAM write in progress
module candy_wb_arbiter
    import candy_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SRAM_ADDR_W    = 16,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned SRAM_WR_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_is_mem,
    input  logic [DATA_W-1:0]      req0_data,
    input  logic [SRAM_ADDR_W-1:0] req0_sram_addr,
    input  logic [REG_ADDR_W-1:0]  req0_reg_addr,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_is_mem,
    input  logic [DATA_W-1:0]      req1_data,
    input  logic [SRAM_ADDR_W-1:0] req1_sram_addr,
    input  logic [REG_ADDR_W-1:0]  req1_reg_addr,
    output logic                   reg_write_enable,
    output logic [REG_ADDR_W-1:0]  reg_waddr,
    output logic [DATA_W-1:0]      reg_wdata,
    output logic                   sram_write_enable,
    output logic [SRAM_ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic                   busy
);

    localparam logic [WbCntWidth-1:0] CntLoad = WbCntWidth'(SRAM_WR_CYCLES);
    localparam logic [WbCntWidth-1:0] CntOne  = WbCntWidth'(1);

    wb_state_e               state_q, state_d;
    logic [WbCntWidth-1:0]   cnt_q, cnt_d;
    logic                    reg_we_q, reg_we_d;
    logic [REG_ADDR_W-1:0]   reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0]       reg_wdata_q, reg_wdata_d;
    logic [SRAM_ADDR_W-1:0]  sram_waddr_q, sram_waddr_d;
    logic [DATA_W-1:0]       sram_wdata_q, sram_wdata_d;

    logic [1:0]              eligible, grant;
    logic                    hs, sel, sel_is_mem;
    logic [DATA_W-1:0]       sel_data;
    logic [SRAM_ADDR_W-1:0]  sel_sram_addr;
    logic [REG_ADDR_W-1:0]   sel_reg_addr;

    // Mem requests are held off while the SRAM port is busy; reg writes always compete.
    assign eligible[0] = req0_valid & (~req0_is_mem | (state_q == WbIdle));
    assign eligible[1] = req1_valid & (~req1_is_mem | (state_q == WbIdle));

    candy_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign hs         = |grant;

    assign sel           = grant[1];
    assign sel_is_mem    = sel ? req1_is_mem    : req0_is_mem;
    assign sel_data      = sel ? req1_data      : req0_data;
    assign sel_sram_addr = sel ? req1_sram_addr : req0_sram_addr;
    assign sel_reg_addr  = sel ? req1_reg_addr  : req0_reg_addr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reg_we_d     = 1'b0;
        reg_waddr_d  = reg_waddr_q;
        reg_wdata_d  = reg_wdata_q;
        sram_waddr_d = sram_waddr_q;
        sram_wdata_d = sram_wdata_q;

        // Writes to r0 complete the handshake but never strobe the register file.
        if (hs && !sel_is_mem && (sel_reg_addr != '0)) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = sel_reg_addr;
            reg_wdata_d = sel_data;
        end

        unique case (state_q)
            WbIdle: begin
                if (hs && sel_is_mem) begin
                    state_d      = WbSramBusy;
                    cnt_d        = CntLoad;
                    sram_waddr_d = sel_sram_addr;
                    sram_wdata_d = sel_data;
                end
            end
            WbSramBusy: begin
                if (cnt_q == CntOne) begin
                    state_d = WbIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WbIdle;
            cnt_q        <= '0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
            sram_waddr_q <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_we_q     <= reg_we_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            sram_waddr_q <= sram_waddr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // The SRAM strobe is the state itself, so an async reset drops it immediately.
    assign reg_write_enable  = reg_we_q;
    assign reg_waddr         = reg_waddr_q;
    assign reg_wdata         = reg_wdata_q;
    assign sram_write_enable = (state_q == WbSramBusy);
    assign sram_waddr        = sram_waddr_q;
    assign sram_wdata        = sram_wdata_q;
    assign busy              = (state_q == WbSramBusy);

endmodule

// File: tb/tb_candy_wb_arbiter.sv
module tb_candy_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_is_mem;
    logic [31:0] req0_data;
    logic [15:0] req0_sram_addr;
    logic [4:0]  req0_reg_addr;
    logic        req1_valid, req1_ready, req1_is_mem;
    logic [31:0] req1_data;
    logic [15:0] req1_sram_addr;
    logic [4:0]  req1_reg_addr;
    logic        reg_write_enable;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        sram_write_enable;
    logic [15:0] sram_waddr;
    logic [31:0] sram_wdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    candy_wb_arbiter #(
        .DATA_W         (32),
        .SRAM_ADDR_W    (16),
        .REG_ADDR_W     (5),
        .SRAM_WR_CYCLES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req0_is_mem       (req0_is_mem),
        .req0_data         (req0_data),
        .req0_sram_addr    (req0_sram_addr),
        .req0_reg_addr     (req0_reg_addr),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .req1_is_mem       (req1_is_mem),
        .req1_data         (req1_data),
        .req1_sram_addr    (req1_sram_addr),
        .req1_reg_addr     (req1_reg_addr),
        .reg_write_enable  (reg_write_enable),
        .reg_waddr         (reg_waddr),
        .reg_wdata         (reg_wdata),
        .sram_write_enable (sram_write_enable),
        .sram_waddr        (sram_waddr),
        .sram_wdata        (sram_wdata),
        .busy              (busy)
    );

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_is_mem = 0; req0_data = '0; req0_sram_addr = '0; req0_reg_addr = '0;
        req1_valid = 0; req1_is_mem = 0; req1_data = '0; req1_sram_addr = '0; req1_reg_addr = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " reg_we"}, 64'(reg_write_enable), 64'd0);
        chk({tag, " reg_waddr"}, 64'(reg_waddr), 64'd0);
        chk({tag, " reg_wdata"}, 64'(reg_wdata), 64'd0);
        chk({tag, " sram_we"}, 64'(sram_write_enable), 64'd0);
        chk({tag, " sram_waddr"}, 64'(sram_waddr), 64'd0);
        chk({tag, " sram_wdata"}, 64'(sram_wdata), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Grant order starts with req0 (pointer resets to 1), then tracks the pointer.
        //          v0 a0  d0            v1 a1  d1            r0 r1 we wa  wd
        vecs[0]  = '{1, 3,  32'hA5A5A5A5, 0, 0,  32'h0,        1, 0, 1, 3,  32'hA5A5A5A5};
        vecs[1]  = '{0, 0,  32'h0,        1, 9,  32'h00000099, 0, 1, 1, 9,  32'h00000099};
        vecs[2]  = '{1, 4,  32'h11111111, 1, 5,  32'h22222222, 1, 0, 1, 4,  32'h11111111};
        vecs[3]  = '{1, 4,  32'h11111111, 1, 5,  32'h22222222, 0, 1, 1, 5,  32'h22222222};
        vecs[4]  = '{1, 4,  32'h11111111, 1, 5,  32'h22222222, 1, 0, 1, 4,  32'h11111111};
        vecs[5]  = '{1, 4,  32'h11111111, 1, 5,  32'h22222222, 0, 1, 1, 5,  32'h22222222};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'h22222222};
        vecs[7]  = '{1, 0,  32'hDEADBEEF, 1, 6,  32'h66666666, 1, 0, 0, 5,  32'h22222222};
        vecs[8]  = '{1, 0,  32'hDEADBEEF, 1, 6,  32'h66666666, 0, 1, 1, 6,  32'h66666666};
        vecs[9]  = '{0, 0,  32'h0,        1, 8,  32'h88888888, 0, 1, 1, 8,  32'h88888888};
        vecs[10] = '{0, 0,  32'h0,        1, 10, 32'hAAAAAAAA, 0, 1, 1, 10, 32'hAAAAAAAA};

        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        chk_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all_zero("after_reset");

        // Register-write vectors, all while IDLE.
        for (int i = 0; i < 11; i++) begin
            req0_valid = vecs[i].v0; req0_is_mem = 0;
            req0_reg_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_is_mem = 0;
            req1_reg_addr = vecs[i].a1; req1_data = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d ready0", i), 64'(req0_ready), 64'(vecs[i].r0));
            chk($sformatf("v%0d ready1", i), 64'(req1_ready), 64'(vecs[i].r1));
            tick();
            chk($sformatf("v%0d reg_we", i), 64'(reg_write_enable), 64'(vecs[i].we));
            chk($sformatf("v%0d reg_waddr", i), 64'(reg_waddr), 64'(vecs[i].wa));
            chk($sformatf("v%0d reg_wdata", i), 64'(reg_wdata), 64'(vecs[i].wd));
        end
        idle_inputs();
        tick();
        chk("reg_we_drops", 64'(reg_write_enable), 64'd0);

        // SRAM write from req1, two-cycle hold, second request waits for IDLE.
        req1_valid = 1; req1_is_mem = 1; req1_sram_addr = 16'h0040; req1_data = 32'h12345678;
        @(negedge clk);
        chk("mem1 ready", 64'(req1_ready), 64'd1);
        tick();
        chk("mem1 c1 we", 64'(sram_write_enable), 64'd1);
        chk("mem1 c1 busy", 64'(busy), 64'd1);
        chk("mem1 c1 addr", 64'(sram_waddr), 64'h0040);
        chk("mem1 c1 data", 64'(sram_wdata), 64'h12345678);
        req1_sram_addr = 16'h0041; req1_data = 32'hCAFEBABE;
        @(negedge clk);
        chk("mem2 blocked c1", 64'(req1_ready), 64'd0);
        tick();
        chk("mem1 c2 we", 64'(sram_write_enable), 64'd1);
        chk("mem1 c2 busy", 64'(busy), 64'd1);
        chk("mem1 c2 addr", 64'(sram_waddr), 64'h0040);
        chk("mem1 c2 data", 64'(sram_wdata), 64'h12345678);
        @(negedge clk);
        chk("mem2 blocked c2", 64'(req1_ready), 64'd0);
        tick();
        chk("mem1 done we", 64'(sram_write_enable), 64'd0);
        chk("mem1 done busy", 64'(busy), 64'd0);
        chk("mem1 addr held", 64'(sram_waddr), 64'h0040);
        @(negedge clk);
        chk("mem2 ready", 64'(req1_ready), 64'd1);
        tick();
        chk("mem2 addr", 64'(sram_waddr), 64'h0041);
        chk("mem2 data", 64'(sram_wdata), 64'hCAFEBABE);

        // Reg write from req0 proceeds while SRAM busy; req1 mem waits.
        req0_valid = 1; req0_is_mem = 0; req0_reg_addr = 5'd7; req0_data = 32'h77777777;
        req1_sram_addr = 16'h0042; req1_data = 32'h42424242;
        @(negedge clk);
        chk("busy reg ready0", 64'(req0_ready), 64'd1);
        chk("busy mem ready1", 64'(req1_ready), 64'd0);
        tick();
        chk("busy reg_we", 64'(reg_write_enable), 64'd1);
        chk("busy reg_waddr", 64'(reg_waddr), 64'd7);
        chk("busy reg_wdata", 64'(reg_wdata), 64'h77777777);
        chk("busy still", 64'(busy), 64'd1);
        req0_valid = 0;
        @(negedge clk);
        chk("mem3 blocked", 64'(req1_ready), 64'd0);
        tick();
        chk("mem2 done busy", 64'(busy), 64'd0);
        chk("reg_we pulse", 64'(reg_write_enable), 64'd0);
        @(negedge clk);
        chk("mem3 ready", 64'(req1_ready), 64'd1);
        tick();
        chk("mem3 busy", 64'(busy), 64'd1);
        chk("mem3 addr", 64'(sram_waddr), 64'h0042);
        req1_valid = 0;

        // Async reset in the middle of an SRAM write.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst abort we", 64'(sram_write_enable), 64'd0);
        chk("rst abort busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all_zero("rerelease");
        req0_valid = 1; req0_reg_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1; req1_is_mem = 0; req1_reg_addr = 5'd2; req1_data = 32'h2;
        @(negedge clk);
        chk("ptr reset ready0", 64'(req0_ready), 64'd1);
        chk("ptr reset ready1", 64'(req1_ready), 64'd0);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
